// File: rtl/playback_scheduler.sv
// Playback sequencer: walks note RAM, loops each note's sample segment and paces ROM reads to the codec.
// Optional PLAYBACK_LOOP_EN: wrap to the first note after the last instead of finishing.
module playback_scheduler #(
   parameter int unsigned NOTE_DEPTH   = 40,
   parameter int unsigned NOTE_W       = 6,
   parameter int unsigned IDX_W        = 6,
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned ROM_NOTE_LEN = 375,
   parameter int unsigned LOOPNUM      = 461
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              play,
   input  logic              stop,
   input  logic [IDX_W-1:0]  i_note,
   input  logic              comp_we,
   input  logic [IDX_W-1:0]  comp_addr,
   input  logic [NOTE_W-1:0] comp_data,
   output logic              comp_grant,
   output logic [IDX_W-1:0]  ram_addr,
   output logic              ram_we,
   output logic [NOTE_W-1:0] ram_wdata,
   input  logic [NOTE_W-1:0] ram_rdata,
   output logic [ADDR_W-1:0] rom_address,
   input  logic              write_ready,
   output logic              write,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CntW = (LOOPNUM > 1) ? $clog2(LOOPNUM) : 1;

   typedef enum logic [2:0] {StIdle, StFetch, StLoad, StPrime, StPlay} state_e;

   state_e            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, n_q;
   logic [CntW-1:0]   cnt_q;
   logic [ADDR_W-1:0] rom_q, base_q;
   logic              done_q;

   logic [IDX_W-1:0]  n_start;
   logic [ADDR_W-1:0] load_base, end_addr;
   logic              seg_end, loop_end, last_note;

   // Note count is clamped to the RAM depth so a bad count cannot walk past the table
   assign n_start   = (32'(i_note) > NOTE_DEPTH) ? IDX_W'(NOTE_DEPTH) : i_note;
   assign load_base = ADDR_W'(ROM_NOTE_LEN * 32'(ram_rdata));
   assign end_addr  = base_q + ADDR_W'(ROM_NOTE_LEN - 1);
   assign seg_end   = (rom_q == end_addr);
   assign loop_end  = (cnt_q == CntW'(LOOPNUM - 1));
   assign last_note = (idx_q == n_q - IDX_W'(1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (play && !stop && i_note != '0) state_d = StFetch;
         StFetch: state_d = stop ? StIdle : StLoad;
         StLoad:  state_d = stop ? StIdle : StPrime;
         StPrime: state_d = stop ? StIdle : StPlay;
         StPlay: begin
            if (stop) begin
               state_d = StIdle;
            end else if (write_ready) begin
               if (!seg_end || !loop_end) begin
                  state_d = StPrime;
               end else if (!last_note) begin
                  state_d = StFetch;
               end else begin
`ifdef PLAYBACK_LOOP_EN
                  state_d = (n_start != '0) ? StFetch : StIdle;
`else
                  state_d = StIdle;
`endif
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy        = (state_q != StIdle);
      write       = (state_q == StPlay) && write_ready && !stop;
      // The RAM port belongs to playback only while fetching
      comp_grant  = comp_we && !reset && (state_q != StFetch);
      ram_we      = comp_grant;
      ram_addr    = (state_q == StFetch) ? idx_q : comp_addr;
      ram_wdata   = comp_data;
      rom_address = rom_q;
      done        = done_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q  <= '0;
         n_q    <= '0;
         cnt_q  <= '0;
         rom_q  <= '0;
         base_q <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (play && !stop) begin
                  if (i_note != '0) begin
                     n_q   <= n_start;
                     idx_q <= '0;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (!stop) begin
                  base_q <= load_base;
                  rom_q  <= load_base;
                  cnt_q  <= '0;
               end
            end
            StPlay: begin
               if (write) begin
                  if (!seg_end) begin
                     rom_q <= rom_q + ADDR_W'(1);
                  end else if (!loop_end) begin
                     cnt_q <= cnt_q + CntW'(1);
                     rom_q <= base_q;
                  end else if (!last_note) begin
                     idx_q <= idx_q + IDX_W'(1);
                  end else begin
`ifdef PLAYBACK_LOOP_EN
                     idx_q <= '0;
                     n_q   <= n_start;
`else
                     done_q <= 1'b1;
`endif
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_playback_scheduler.sv
// Scoreboard bench for playback_scheduler (ROM_NOTE_LEN=4, LOOPNUM=2).
// Define PLAYBACK_LOOP_EN for both files to run the looping scenario instead.
module tb_playback_scheduler;

   localparam int unsigned LEN = 4;
   localparam int unsigned LOOPS = 2;

   logic        clk = 1'b0;
   logic        reset, play, stop, comp_we, comp_grant, ram_we, write_ready, write, busy, done;
   logic [5:0]  i_note, comp_addr, ram_addr;
   logic [5:0]  comp_data, ram_wdata, ram_rdata;
   logic [14:0] rom_address;

   typedef struct packed {
      logic [14:0] addr;
      logic [1:0]  kind;   // 0 mid-note, 1 note end then fetch, 2 playback end
   } exp_t;

   exp_t       sb[$];
   logic [5:0] mem [64];
   int         n_checks = 0, n_fail = 0, write_cnt = 0, done_cnt = 0;
   bit         cur_fetch = 0, model_idle = 1;

   playback_scheduler #(.ROM_NOTE_LEN(LEN), .LOOPNUM(LOOPS)) dut (
      .clk(clk), .reset(reset), .play(play), .stop(stop), .i_note(i_note),
      .comp_we(comp_we), .comp_addr(comp_addr), .comp_data(comp_data), .comp_grant(comp_grant),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .rom_address(rom_address), .write_ready(write_ready), .write(write), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard and arbitration model, sampled mid-cycle
   always @(negedge clk) begin
      bit   nxt;
      exp_t e;
      if (reset) begin
         model_idle = 1;
         cur_fetch  = 0;
      end else begin
         if (comp_we) check_eq("comp_grant", comp_grant, !cur_fetch);
         nxt = 0;
         if (done) done_cnt++;
         if (stop) begin
            model_idle = 1;
         end else if (model_idle && play && i_note != 0) begin
            nxt = 1;
            model_idle = 0;
         end
         if (write) begin
            write_cnt++;
            if (sb.size() == 0) begin
               check_eq("spurious_write", rom_address, 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               check_eq("rom_address", rom_address, e.addr);
               if (e.kind == 2'd1) nxt = 1;
               if (e.kind == 2'd2) model_idle = 1;
            end
         end
         cur_fetch = nxt;
      end
   end

   task automatic push_note(input int note, input int end_kind);
      for (int l = 0; l < LOOPS; l++)
         for (int k = 0; k < LEN; k++)
            sb.push_back('{addr: 15'(note * LEN + k),
                           kind: (l == LOOPS - 1 && k == LEN - 1) ? 2'(end_kind) : 2'd0});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic comp_write(input int a, input int d);
      comp_we = 1; comp_addr = 6'(a); comp_data = 6'(d);
      tick();
      comp_we = 0;
   endtask

   task automatic start_play(input int n);
      i_note = 6'(n); play = 1;
      tick();
      play = 0;
   endtask

   task automatic wait_done(input int budget);
      bit hit = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (done) begin hit = 1; break; end
      end
      check_eq("done_seen", hit, 1);
   endtask

   task automatic wait_addr(input int a, input int budget);
      bit hit = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         if (write && rom_address == 15'(a)) begin hit = 1; break; end
      end
      check_eq("addr_reached", hit, 1);
   endtask

   initial begin
      int wc, dc;
      reset = 1; play = 0; stop = 0; i_note = 0; comp_we = 1; comp_addr = 0; comp_data = 0;
      write_ready = 1;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      #12;
      check_eq("rst_comp_grant", comp_grant, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_write", write, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_rom_address", rom_address, 0);
      comp_we = 0;
      tick();
      reset = 0;
      tick();

`ifdef PLAYBACK_LOOP_EN
      comp_write(0, 1);
      for (int r = 0; r < 3; r++) push_note(1, 1);
      dc = done_cnt;
      start_play(1);
      for (int i = 0; i < 400 && sb.size() != 0; i++) tick();
      check_eq("loop_drained", sb.size(), 0);
      check_eq("loop_busy", busy, 1);
      stop = 1;
      tick();
      stop = 0;
      check_eq("loop_stop_busy", busy, 0);
      check_eq("loop_no_done", done_cnt - dc, 0);
`else
      // Two notes, free-running codec
      comp_write(0, 3);
      comp_write(1, 5);
      push_note(3, 1);
      push_note(5, 2);
      wc = write_cnt; dc = done_cnt;
      start_play(2);
      check_eq("busy_playing", busy, 1);
      wait_done(200);
      check_eq("end_busy", busy, 0);
      check_eq("end_writes", write_cnt - wc, 16);
      tick();
      check_eq("done_width", done_cnt - dc, 1);
      check_eq("sb_empty_1", sb.size(), 0);

      // Codec stall mid-note
      push_note(3, 1);
      push_note(5, 2);
      wc = write_cnt;
      start_play(2);
      wait_addr(14, 100);
      write_ready = 0;
      #1;
      check_eq("stall_write_low", write, 0);
      repeat (10) tick();
      check_eq("stall_addr_held", rom_address, 14);
      check_eq("stall_busy", busy, 1);
      write_ready = 1;
      wait_done(200);
      check_eq("stall_writes", write_cnt - wc, 16);
      check_eq("sb_empty_2", sb.size(), 0);
      tick();

      // Empty note list
      wc = write_cnt; dc = done_cnt;
      start_play(0);
      check_eq("empty_done", done, 1);
      check_eq("empty_busy", busy, 0);
      tick();
      check_eq("empty_done_clear", done, 0);
      check_eq("empty_writes", write_cnt - wc, 0);

      // Composer holds a write request across a whole playback
      push_note(3, 1);
      push_note(5, 2);
      comp_we = 1; comp_addr = 20; comp_data = 9;
      start_play(2);
      wait_done(200);
      comp_we = 0;
      tick();
      check_eq("ram20", mem[20], 9);
      check_eq("ram0", mem[0], 3);
      check_eq("ram1", mem[1], 5);
      check_eq("sb_empty_4", sb.size(), 0);

      // Stop at address 13
      sb.push_back('{addr: 15'd12, kind: 2'd0});
      dc = done_cnt;
      start_play(2);
      wait_addr(13, 100);
      stop = 1;
      #1;
      check_eq("stop_write", write, 0);
      tick();
      check_eq("stop_busy", busy, 0);
      check_eq("stop_write_next", write, 0);
      stop = 0;
      repeat (3) tick();
      check_eq("stop_no_done", done_cnt - dc, 0);
      check_eq("stop_sb", sb.size(), 0);

      // Reset at address 13
      sb.push_back('{addr: 15'd12, kind: 2'd0});
      start_play(2);
      wait_addr(13, 100);
      reset = 1;
      #1;
      check_eq("rstmid_write", write, 0);
      check_eq("rstmid_busy", busy, 0);
      check_eq("rstmid_addr", rom_address, 0);
      tick();
      reset = 0;
      repeat (3) tick();
      check_eq("rstmid_no_done", done_cnt - dc, 0);
      check_eq("rstmid_sb", sb.size(), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
